// File: rtl/adder_arb_pkg.sv
// Shared definitions for the two-requester adder arbiter: datapath width,
// requester ids, response-slot states and the last-grant reset value.
package adder_arb_pkg;

  localparam int P_WIDTH = 64;

  // Requester identifiers as carried on the grant path.
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Response slot occupancy.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Last grant comes up as requester 1 so requester 0 wins the first tie.
  localparam logic LAST_GRANT_RST = REQ1;

  // Conditionally invert an operand; used to turn add into subtract.
  function automatic logic [P_WIDTH-1:0] cond_invert(input logic [P_WIDTH-1:0] value,
                                                     input logic              invert);
    return value ^ {P_WIDTH{invert}};
  endfunction

endpackage

// File: rtl/m_adder.sv
// 64-bit carry-select adder: 16-bit blocks each compute both carry-in
// hypotheses and the incoming block carry picks one. Purely combinational.
module m_adder
  import adder_arb_pkg::*;
(
  input  logic [P_WIDTH-1:0] a,
  input  logic [P_WIDTH-1:0] b,
  input  logic               cin,
  output logic [P_WIDTH-1:0] sum,
  output logic               cout
);

  localparam int BLK  = 16;
  localparam int NBLK = P_WIDTH / BLK;

  logic [NBLK:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < NBLK; i++) begin : g_blk
    logic [BLK:0] res_c0_s;
    logic [BLK:0] res_c1_s;

    assign res_c0_s = {1'b0, a[i*BLK +: BLK]} + {1'b0, b[i*BLK +: BLK]};
    assign res_c1_s = {1'b0, a[i*BLK +: BLK]} + {1'b0, b[i*BLK +: BLK]} + 17'd1;

    assign sum[i*BLK +: BLK] = carry_s[i] ? res_c1_s[BLK-1:0] : res_c0_s[BLK-1:0];
    assign carry_s[i+1]      = carry_s[i] ? res_c1_s[BLK]     : res_c0_s[BLK];
  end

  assign cout = carry_s[NBLK];

endmodule

// File: rtl/m_adder_rsp_slot.sv
// One-entry registered response slot for one requester. It fills on an
// accept, empties on a response handshake, and stays full on a same-cycle
// drain plus refill so a single requester can run at one result per cycle.
module m_adder_rsp_slot
  import adder_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fill,
  input  logic [P_WIDTH-1:0] fill_sum,
  input  logic               fill_cout,
  input  logic               rsp_ready,
  output logic               rsp_valid,
  output logic [P_WIDTH-1:0] rsp_sum,
  output logic               rsp_cout,
  output logic               free
);

  slot_state_t        state_r;
  slot_state_t        state_s;
  logic [P_WIDTH-1:0] sum_r;
  logic               cout_r;
  logic               drain_s;

  assign drain_s   = (state_r == SLOT_FULL) & rsp_ready;
  assign free      = (state_r == SLOT_EMPTY) | drain_s;
  assign rsp_valid = (state_r == SLOT_FULL);
  assign rsp_sum   = sum_r;
  assign rsp_cout  = cout_r;

  // Next occupancy from fill and drain.
  always_comb begin
    state_s = state_r;
    case (state_r)
      SLOT_EMPTY: begin
        if (fill) begin
          state_s = SLOT_FULL;
        end else begin
          state_s = SLOT_EMPTY;
        end
      end
      SLOT_FULL: begin
        if (fill) begin
          state_s = SLOT_FULL;
        end else if (rsp_ready) begin
          state_s = SLOT_EMPTY;
        end else begin
          state_s = SLOT_FULL;
        end
      end
      default: state_s = SLOT_EMPTY;
    endcase
  end

  // Occupancy register; reset drops any held result without a handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= SLOT_EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // Result register; loads only on accept so a stalled response stays stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_r  <= {P_WIDTH{1'b0}};
      cout_r <= 1'b0;
    end else if (fill) begin
      sum_r  <= fill_sum;
      cout_r <= fill_cout;
    end else begin
      sum_r  <= sum_r;
      cout_r <= cout_r;
    end
  end

endmodule

// File: rtl/m_adder_arbiter.sv
// Shares one carry-select adder between two requesters. A combinational
// arbiter grants at most one eligible requester per cycle (round-robin or
// fixed priority); the result lands in that requester's response slot one
// cycle later.
module m_adder_arbiter #(
  parameter bit P_RR_EN = 1'b1,
  parameter int P_WIDTH = 64
) (
  input  logic               i_clk_1,
  input  logic               i_rstN_1,
  input  logic               i_req0Valid_1,
  output logic               o_req0Ready_1,
  input  logic [P_WIDTH-1:0] i_req0Op1_64,
  input  logic [P_WIDTH-1:0] i_req0Op2_64,
  input  logic               i_req0Sub_1,
  output logic               o_rsp0Valid_1,
  input  logic               i_rsp0Ready_1,
  output logic [P_WIDTH-1:0] o_rsp0Sum_64,
  output logic               o_rsp0Cout_1,
  input  logic               i_req1Valid_1,
  output logic               o_req1Ready_1,
  input  logic [P_WIDTH-1:0] i_req1Op1_64,
  input  logic [P_WIDTH-1:0] i_req1Op2_64,
  input  logic               i_req1Sub_1,
  output logic               o_rsp1Valid_1,
  input  logic               i_rsp1Ready_1,
  output logic [P_WIDTH-1:0] o_rsp1Sum_64,
  output logic               o_rsp1Cout_1
);

  import adder_arb_pkg::*;

  logic               last_grant_r;
  logic               grant_valid_s;
  logic               grant_id_s;
  logic               free0_s;
  logic               free1_s;
  logic               elig0_s;
  logic               elig1_s;
  logic [P_WIDTH-1:0] add_a_s;
  logic [P_WIDTH-1:0] add_b_s;
  logic               add_cin_s;
  logic [P_WIDTH-1:0] add_sum_s;
  logic               add_cout_s;
  logic               fill0_s;
  logic               fill1_s;

  assign elig0_s = i_req0Valid_1 & free0_s;
  assign elig1_s = i_req1Valid_1 & free1_s;

  // Pick at most one requester; nothing is granted while reset is asserted.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = REQ0;
    if (!i_rstN_1) begin
      grant_valid_s = 1'b0;
      grant_id_s    = REQ0;
    end else if (elig0_s && elig1_s) begin
      grant_valid_s = 1'b1;
      if (P_RR_EN) begin
        grant_id_s = ~last_grant_r;
      end else begin
        grant_id_s = REQ0;
      end
    end else if (elig0_s) begin
      grant_valid_s = 1'b1;
      grant_id_s    = REQ0;
    end else if (elig1_s) begin
      grant_valid_s = 1'b1;
      grant_id_s    = REQ1;
    end else begin
      grant_valid_s = 1'b0;
      grant_id_s    = REQ0;
    end
  end

  assign fill0_s       = grant_valid_s & (grant_id_s == REQ0);
  assign fill1_s       = grant_valid_s & (grant_id_s == REQ1);
  assign o_req0Ready_1 = fill0_s;
  assign o_req1Ready_1 = fill1_s;

  // Steer the granted request onto the shared adder; subtract is a + ~b + 1.
  always_comb begin
    add_a_s   = i_req0Op1_64;
    add_b_s   = cond_invert(i_req0Op2_64, i_req0Sub_1);
    add_cin_s = i_req0Sub_1;
    if (grant_id_s == REQ1) begin
      add_a_s   = i_req1Op1_64;
      add_b_s   = cond_invert(i_req1Op2_64, i_req1Sub_1);
      add_cin_s = i_req1Sub_1;
    end else begin
      add_a_s   = i_req0Op1_64;
      add_b_s   = cond_invert(i_req0Op2_64, i_req0Sub_1);
      add_cin_s = i_req0Sub_1;
    end
  end

  // Remember who won last so the next tie goes the other way.
  always_ff @(posedge i_clk_1) begin
    if (!i_rstN_1) begin
      last_grant_r <= LAST_GRANT_RST;
    end else if (grant_valid_s) begin
      last_grant_r <= grant_id_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  m_adder u_adder (
    .a    (add_a_s),
    .b    (add_b_s),
    .cin  (add_cin_s),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  m_adder_rsp_slot u_slot0 (
    .clk       (i_clk_1),
    .rst_n     (i_rstN_1),
    .fill      (fill0_s),
    .fill_sum  (add_sum_s),
    .fill_cout (add_cout_s),
    .rsp_ready (i_rsp0Ready_1),
    .rsp_valid (o_rsp0Valid_1),
    .rsp_sum   (o_rsp0Sum_64),
    .rsp_cout  (o_rsp0Cout_1),
    .free      (free0_s)
  );

  m_adder_rsp_slot u_slot1 (
    .clk       (i_clk_1),
    .rst_n     (i_rstN_1),
    .fill      (fill1_s),
    .fill_sum  (add_sum_s),
    .fill_cout (add_cout_s),
    .rsp_ready (i_rsp1Ready_1),
    .rsp_valid (o_rsp1Valid_1),
    .rsp_sum   (o_rsp1Sum_64),
    .rsp_cout  (o_rsp1Cout_1),
    .free      (free1_s)
  );

endmodule

// File: tb/tb_m_adder_arbiter.sv
// Bench for m_adder_arbiter: directed table, hand-written contention and
// backpressure sequences, then random traffic against a transaction-level model.
module tb_m_adder_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       vld;
  logic [1:0]       sub;
  logic [1:0]       rr;
  logic [1:0][63:0] op1;
  logic [1:0][63:0] op2;

  logic [1:0]       rdy, rv, rc;
  logic [1:0][63:0] rsum;
  logic [1:0]       rdy_fp, rv_fp, rc_fp;
  logic [1:0][63:0] rsum_fp;

  int total = 0;
  int bad   = 0;

  m_adder_arbiter #(.P_RR_EN(1'b1), .P_WIDTH(64)) u_dut (
    .i_clk_1(clk), .i_rstN_1(rst_n),
    .i_req0Valid_1(vld[0]), .o_req0Ready_1(rdy[0]), .i_req0Op1_64(op1[0]),
    .i_req0Op2_64(op2[0]), .i_req0Sub_1(sub[0]), .o_rsp0Valid_1(rv[0]),
    .i_rsp0Ready_1(rr[0]), .o_rsp0Sum_64(rsum[0]), .o_rsp0Cout_1(rc[0]),
    .i_req1Valid_1(vld[1]), .o_req1Ready_1(rdy[1]), .i_req1Op1_64(op1[1]),
    .i_req1Op2_64(op2[1]), .i_req1Sub_1(sub[1]), .o_rsp1Valid_1(rv[1]),
    .i_rsp1Ready_1(rr[1]), .o_rsp1Sum_64(rsum[1]), .o_rsp1Cout_1(rc[1])
  );

  m_adder_arbiter #(.P_RR_EN(1'b0), .P_WIDTH(64)) u_dut_fp (
    .i_clk_1(clk), .i_rstN_1(rst_n),
    .i_req0Valid_1(vld[0]), .o_req0Ready_1(rdy_fp[0]), .i_req0Op1_64(op1[0]),
    .i_req0Op2_64(op2[0]), .i_req0Sub_1(sub[0]), .o_rsp0Valid_1(rv_fp[0]),
    .i_rsp0Ready_1(rr[0]), .o_rsp0Sum_64(rsum_fp[0]), .o_rsp0Cout_1(rc_fp[0]),
    .i_req1Valid_1(vld[1]), .o_req1Ready_1(rdy_fp[1]), .i_req1Op1_64(op1[1]),
    .i_req1Op2_64(op2[1]), .i_req1Sub_1(sub[1]), .o_rsp1Valid_1(rv_fp[1]),
    .i_rsp1Ready_1(rr[1]), .o_rsp1Sum_64(rsum_fp[1]), .o_rsp1Cout_1(rc_fp[1])
  );

  // Reference model: per-requester slot contents and who won the last accept.
  bit          m_full [2];
  logic [63:0] m_sum  [2];
  bit          m_cout [2];
  bit          m_last;
  int          m_g;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Arithmetic result as {carry-out, sum}; subtract carry means "no borrow".
  function automatic logic [64:0] ref_op(input logic [63:0] a, input logic [63:0] b,
                                         input logic s);
    logic [64:0] r;
    if (s) begin
      r = {(a >= b), a - b};
    end else begin
      r = {1'b0, a} + {1'b0, b};
    end
    return r;
  endfunction

  function automatic int model_grant();
    bit e0, e1;
    if (!rst_n) return -1;
    e0 = vld[0] && (!m_full[0] || rr[0]);
    e1 = vld[1] && (!m_full[1] || rr[1]);
    if (e0 && e1) return (m_last == 1'b1) ? 0 : 1;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  // One clock: inputs already driven; check grant, advance model, check outputs.
  task automatic tick();
    logic [64:0] r;
    #1;
    m_g = model_grant();
    chk("ready0", rdy[0], (m_g == 0));
    chk("ready1", rdy[1], (m_g == 1));
    @(posedge clk);
    if (!rst_n) begin
      for (int x = 0; x < 2; x++) begin
        m_full[x] = 0; m_sum[x] = 64'd0; m_cout[x] = 0;
      end
      m_last = 1'b1;
    end else begin
      for (int x = 0; x < 2; x++) begin
        if (m_g == x) begin
          r = ref_op(op1[x], op2[x], sub[x]);
          m_full[x] = 1; m_sum[x] = r[63:0]; m_cout[x] = r[64];
        end else if (m_full[x] && rr[x]) begin
          m_full[x] = 0;
        end
      end
      if (m_g >= 0) m_last = (m_g == 1);
    end
    @(negedge clk);
    for (int x = 0; x < 2; x++) begin
      chk($sformatf("rsp%0d_valid", x), rv[x], m_full[x]);
      chk($sformatf("rsp%0d_sum", x), rsum[x], m_sum[x]);
      chk($sformatf("rsp%0d_cout", x), rc[x], m_cout[x]);
    end
  endtask

  typedef struct {
    bit          id;
    logic [63:0] a;
    logic [63:0] b;
    bit          s;
    logic [63:0] es;
    bit          ec;
  } vec_t;

  vec_t tbl [4];
  bit   acc [2];

  initial begin
    tbl[0] = '{1'b0, 64'h5, 64'h3, 1'b0, 64'h8, 1'b0};
    tbl[1] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1};
    tbl[2] = '{1'b1, 64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    tbl[3] = '{1'b1, 64'h7, 64'h5, 1'b1, 64'h2, 1'b1};

    m_full[0] = 0; m_full[1] = 0; m_sum[0] = 64'd0; m_sum[1] = 64'd0;
    m_cout[0] = 0; m_cout[1] = 0; m_last = 1'b1; m_g = -1;

    // Reset held two cycles with both requesters asking.
    rst_n = 1'b0; vld = 2'b11; sub = 2'b00; rr = 2'b11;
    op1 = '0; op2 = '0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("reset_ready", rdy, 2'b00);
      tick();
      chk("reset_valid", rv, 2'b00);
      chk("reset_sum0", rsum[0], 64'd0);
      chk("reset_sum1", rsum[1], 64'd0);
    end

    // First tie after reset goes to requester 0.
    rst_n = 1'b1;
    #1;
    chk("first_tie", rdy, 2'b01);
    tick();
    vld = 2'b00;

    // Directed arithmetic vectors.
    for (int i = 0; i < 4; i++) begin
      vld = 2'b00;
      vld[tbl[i].id] = 1'b1;
      op1[tbl[i].id] = tbl[i].a;
      op2[tbl[i].id] = tbl[i].b;
      sub[tbl[i].id] = tbl[i].s;
      rr = 2'b11;
      tick();
      vld = 2'b00;
      chk($sformatf("tbl%0d_valid", i), rv[tbl[i].id], 1'b1);
      chk($sformatf("tbl%0d_sum", i), rsum[tbl[i].id], tbl[i].es);
      chk($sformatf("tbl%0d_cout", i), rc[tbl[i].id], tbl[i].ec);
    end

    // Contention with consumers always ready: alternate vs fixed priority.
    vld = 2'b11; rr = 2'b11; sub = 2'b00;
    for (int i = 0; i < 4; i++) begin
      op1[0] = 64'(i); op2[0] = 64'd100;
      op1[1] = 64'(i); op2[1] = 64'd200;
      #1;
      chk($sformatf("rr_grant%0d", i), rdy, ((i % 2) == 0) ? 2'b01 : 2'b10);
      chk($sformatf("fp_grant%0d", i), rdy_fp, 2'b01);
      tick();
    end

    // Backpressure: fill slot 0, stall it, requester 1 keeps flowing.
    vld = 2'b01; rr = 2'b10; sub = 2'b00;
    op1[0] = 64'h10; op2[0] = 64'h20;
    tick();
    op1[0] = 64'h100; op2[0] = 64'h1;
    for (int i = 0; i < 3; i++) begin
      vld = 2'b11;
      op1[1] = 64'(1000 + i); op2[1] = 64'd1;
      #1;
      chk("bp_ready0", rdy[0], 1'b0);
      chk("bp_ready1", rdy[1], 1'b1);
      chk("bp_hold_sum", rsum[0], 64'h30);
      chk("bp_hold_valid", rv[0], 1'b1);
      tick();
    end
    // Release: drain and refill slot 0 in the same cycle.
    vld = 2'b01; rr = 2'b11;
    #1;
    chk("bp_release_ready", rdy[0], 1'b1);
    tick();
    chk("b2b_valid", rv[0], 1'b1);
    chk("b2b_sum", rsum[0], 64'h101);
    vld = 2'b00;
    tick();

    // Random traffic, including occasional resets mid-operation.
    acc[0] = 0; acc[1] = 0;
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      for (int x = 0; x < 2; x++) begin
        if (!(vld[x] && !acc[x])) begin
          vld[x] = ($urandom_range(0, 3) != 0);
          op1[x] = ($urandom_range(0, 5) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF
                                               : {$urandom, $urandom};
          op2[x] = ($urandom_range(0, 5) == 0) ? op1[x] : {$urandom, $urandom};
          sub[x] = $urandom_range(0, 1);
        end
        rr[x] = ($urandom_range(0, 9) < 7);
      end
      tick();
      acc[0] = (m_g == 0);
      acc[1] = (m_g == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/m_adder_arbiter.md
Name: m_adder_arbiter

Overview:
- Shares one 64-bit carry-select adder (`m_adder`) between two requesters, e.g. the ALU path and the branch/AGU target path.
- Each requester has a valid/ready request channel and a one-entry registered response slot with its own valid/ready handshake.
- Supports add and subtract (two's complement via operand inversion and carry-in).
- Issues at most one operation per cycle, with round-robin or fixed-priority selection.

Parameters:
- P_RR_EN, 1, 1 = round-robin between requesters on contention; 0 = fixed priority, requester 0 always wins.
- P_WIDTH, 64, datapath width. Fixed to the `m_adder` width; any other value is illegal.

Ports:
- i_clk_1  input  1  clock; all state updates on the rising edge.
- i_rstN_1  input  1  synchronous reset, active-low.
- i_req0Valid_1  input  1  requester 0 has an operation.
- o_req0Ready_1  output  1  requester 0 operation accepted this cycle.
- i_req0Op1_64  input  64  requester 0 operand 1.
- i_req0Op2_64  input  64  requester 0 operand 2.
- i_req0Sub_1  input  1  requester 0: 1 = Op1-Op2, 0 = Op1+Op2.
- o_rsp0Valid_1  output  1  requester 0 result slot full.
- i_rsp0Ready_1  input  1  requester 0 consumes the result.
- o_rsp0Sum_64  output  64  requester 0 result.
- o_rsp0Cout_1  output  1  requester 0 carry-out (for subtract, 1 = no borrow).
- i_req1Valid_1, o_req1Ready_1, i_req1Op1_64, i_req1Op2_64, i_req1Sub_1, o_rsp1Valid_1, i_rsp1Ready_1, o_rsp1Sum_64, o_rsp1Cout_1: same as requester 0, for requester 1.

Behaviour:
- Reset: on a rising edge with i_rstN_1 low:
  - both response slots go EMPTY;
  - o_rspXValid_1 = 0, o_rspXSum_64 = 0, o_rspXCout_1 = 0;
  - last-grant register r_lastGrant_1 = 1, so requester 0 wins the first tie.
- While i_rstN_1 is low, o_reqXReady_1 = 0 regardless of the valids.
- Reset mid-operation discards any held results without a response handshake.
- Slot state per requester, EMPTY/FULL:
  - EMPTY -> FULL on that requester's accept.
  - FULL -> EMPTY when rspValid & rspReady and no new accept.
  - FULL stays FULL when drained and re-accepted in the same cycle (back-to-back).
- Eligibility: requester X is eligible when reqXValid = 1 and its slot is EMPTY or is being drained this cycle (rspXValid & rspXReady).
- Grant (combinational, at most one):
  - Only one requester eligible: grant it.
  - Both eligible, P_RR_EN = 1: grant ~r_lastGrant_1.
  - Both eligible, P_RR_EN = 0: grant requester 0.
  - o_reqXReady_1 = grant to X.
- Accept: when reqXValid & reqXReady:
  - Adder inputs: operand1 = Op1; operand2 = Op2 ^ {64{Sub}}; carry-in = Sub.
  - Sum and carry-out are registered into slot X at the edge, so rspXValid = 1 on the next cycle (latency 1).
  - r_lastGrant_1 <= X.
  - r_lastGrant_1 is unchanged when there is no accept.
- Response stability: while rspXValid = 1 and rspXReady = 0, Sum and Cout are held stable.
- Throughput:
  - Combined throughput is one operation per cycle.
  - A single requester with its consumer always ready sustains one per cycle.
- Handshake rules:
  - Requesters must not make reqValid depend on reqReady.
  - Operands must be held stable while valid and not ready; the block does not check this.
- Adder combinational path: `m_adder` inputs come directly from the selected request mux. No state is held in the adder.
- Arithmetic: modulo 2^64. No overflow flag; signed overflow is derived externally from operand and sum signs.

Decomposition:
- Shared package `adder_arb_pkg`:
  - P_WIDTH = 64;
  - requester id constants REQ0 = 1'b0, REQ1 = 1'b1;
  - slot encodings SLOT_EMPTY / SLOT_FULL;
  - reset value of r_lastGrant_1.
- Sub-modules:
  - One existing `m_adder` instance performs the arithmetic.
  - One new per-requester sub-module, `m_adder_rsp_slot`, holds the slot register, valid, and drain/fill logic; it is instantiated twice.

Test Plan:
- Reset: hold i_rstN_1 low 2 cycles with both reqValid = 1 -> both reqReady = 0, rspValid = 0, Sum = 0. First cycle after release, both valid -> requester 0 granted.
- Add: req0 Op1 = 0x5, Op2 = 0x3, Sub = 0 -> next cycle rsp0Valid = 1, Sum = 0x8, Cout = 0.
- Add carry-out: req0 Op1 = 0xFFFF_FFFF_FFFF_FFFF, Op2 = 0x1, Sub = 0 -> Sum = 0x0, Cout = 1.
- Subtract, two cases on req1:
  - Op1 = 0x5, Op2 = 0x7, Sub = 1 -> Sum = 0xFFFF_FFFF_FFFF_FFFE, Cout = 0.
  - Op1 = 0x7, Op2 = 0x5, Sub = 1 -> Sum = 0x2, Cout = 1.
- Contention, both valid continuously with both rspReady = 1:
  - P_RR_EN = 1 -> grants alternate 0,1,0,1.
  - P_RR_EN = 0 -> req0 granted every cycle and req1 starves.
- Backpressure:
  - Hold rsp0Ready = 0 with slot 0 FULL -> req0Ready = 0, rsp0 Sum stable, req1 still accepted each cycle.
  - Then raise rsp0Ready with req0Valid = 1 and req1Valid = 0 -> drain and new accept in the same cycle; rsp0Valid stays 1 with the new Sum.
